// File: rtl/ln_share_arb.sv
// ln_share_arb: round-robin sharing of one fixed-latency natural-log unit
// among NUM_REQ softmax lanes, with tag tracking and a drain/flush FSM.
// Optional input-domain checker enabled by defining LN_ARB_DOMAIN_CHK_EN.
module ln_share_arb #(
  parameter int DATAWIDTH  = 16,
  parameter int NUM_REQ    = 4,
  parameter int TAGW       = 2,
  parameter int LN_LATENCY = 0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATAWIDTH-1:0]           ln_in_data,
  output logic                           ln_in_valid,
  input  logic [DATAWIDTH-1:0]           ln_out_data,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATAWIDTH-1:0]           resp_data,
  output logic [TAGW-1:0]                resp_tag,
  output logic                           busy,
  output logic                           flush_done
`ifdef LN_ARB_DOMAIN_CHK_EN
  ,
  output logic                           dom_err,
  output logic [TAGW-1:0]                dom_err_tag
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  localparam logic [TAGW:0] NREQ = (TAGW+1)'(NUM_REQ);

  state_t               state;
  state_t               state_nxt;
  logic [TAGW-1:0]      ptr;
  logic [TAGW-1:0]      ptr_nxt;
  logic [TAGW:0]        ptr_inc;
  logic [TAGW:0]        cand;
  logic [TAGW-1:0]      gnt_idx;
  logic                 gnt_found;
  logic                 grant_en;
  logic                 accept;
  logic [DATAWIDTH-1:0] operand;
  logic [LN_LATENCY:0]  stg_vld;
  logic [TAGW-1:0]      stg_tag [0:LN_LATENCY];
  logic                 pipe_empty;

  // Flush or a dropped enable blocks grants in the same cycle it is seen
  assign grant_en = (state == ACTIVE) && enable && !flush;
  assign accept   = grant_en && gnt_found;
  assign operand  = req_data[gnt_idx*DATAWIDTH +: DATAWIDTH];

  // Search for the first valid lane starting at the pointer, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (TAGW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid[cand[TAGW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[TAGW-1:0];
      end
    end
  end

  // One-hot grant and the pointer value just past the granted lane
  always_comb begin
    req_ready = '0;
    ptr_inc   = {1'b0, gnt_idx} + (TAGW+1)'(1);
    ptr_nxt   = (ptr_inc == NREQ) ? '0 : ptr_inc[TAGW-1:0];
    if (accept) req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
  end

  // Round-robin pointer advances only when a request is taken
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     ptr <= '0;
    else if (accept) ptr <= ptr_nxt;
  end

  // Operand register plus tag/valid chain that mirrors the ln unit latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ln_in_data <= '0;
      stg_vld    <= '0;
      for (int s = 0; s <= LN_LATENCY; s++) stg_tag[s] <= '0;
    end else begin
      stg_vld[0] <= accept;
      if (accept) begin
        ln_in_data <= operand;
        stg_tag[0] <= gnt_idx;
      end
      for (int s = 1; s <= LN_LATENCY; s++) begin
        stg_vld[s] <= stg_vld[s-1];
        stg_tag[s] <= stg_tag[s-1];
      end
    end
  end

  assign ln_in_valid = stg_vld[0];

  // Capture the ln result as the tag leaves the chain and steer it to its lane
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else if (stg_vld[LN_LATENCY]) begin
      resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << stg_tag[LN_LATENCY];
      resp_data  <= ln_out_data;
      resp_tag   <= stg_tag[LN_LATENCY];
    end else begin
      resp_valid <= '0;
    end
  end

  assign pipe_empty = ~|stg_vld && ~|resp_valid;
  assign busy       = (state != IDLE) || !pipe_empty;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and drain completion pulse
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      IDLE:    if (enable && !flush) state_nxt = ACTIVE;
      ACTIVE:  if (flush || !enable) state_nxt = DRAIN;
      DRAIN: begin
        if (pipe_empty) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LN_ARB_DOMAIN_CHK_EN
  logic operand_bad;

  assign operand_bad = operand[DATAWIDTH-1] || (operand[DATAWIDTH-2:0] == '0);

  // Sticky flag for ln operands outside (0, +inf); first offender is kept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dom_err     <= 1'b0;
      dom_err_tag <= '0;
    end else if (flush_done) begin
      dom_err     <= 1'b0;
      dom_err_tag <= '0;
    end else if (accept && operand_bad && !dom_err) begin
      dom_err     <= 1'b1;
      dom_err_tag <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_ln_share_arb.sv
// tb_ln_share_arb: directed scoreboard bench for ln_share_arb.
// dut0 uses a combinational ln model, dut3 a three-cycle ln model.
// Domain-check steps are compiled in when LN_ARB_DOMAIN_CHK_EN is defined.
module tb_ln_share_arb;

  typedef struct {
    logic [1:0]  tag;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;

  logic        enable0, flush0, ln_in_valid0, busy0, flush_done0;
  logic [3:0]  req_valid0, req_ready0, resp_valid0;
  logic [63:0] req_data0;
  logic [15:0] ln_in_data0, ln_out_data0, resp_data0;
  logic [1:0]  resp_tag0;

  logic        enable3, flush3, ln_in_valid3, busy3, flush_done3;
  logic [3:0]  req_valid3, req_ready3, resp_valid3;
  logic [63:0] req_data3;
  logic [15:0] ln_in_data3, ln_out_data3, resp_data3;
  logic [1:0]  resp_tag3;
  logic [15:0] ln_d1, ln_d2, ln_d3;

`ifdef LN_ARB_DOMAIN_CHK_EN
  logic       dom_err0, dom_err3;
  logic [1:0] dom_err_tag0, dom_err_tag3;
`endif

  exp_t q0[$];
  exp_t q3[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_due;
  int   fd_count;
  int   fd_cyc;
  logic [63:0] rrd;

  // Stand-in ln table: exact values for the test operands, a fixed scramble otherwise
  function automatic logic [15:0] ln_model(input logic [15:0] x);
    case (x)
      16'h3C00: ln_model = 16'h0000;
      16'h4000: ln_model = 16'h398C;
      16'h4200: ln_model = 16'h3C65;
      16'h4400: ln_model = 16'h3D8C;
      default:  ln_model = x ^ 16'h5A5A;
    endcase
  endfunction

  always #5 clk = ~clk;

  assign ln_out_data0 = ln_model(ln_in_data0);

  // Three-stage ln model for the latency-3 instance
  always @(posedge clk) begin
    ln_d1 <= ln_model(ln_in_data3);
    ln_d2 <= ln_d1;
    ln_d3 <= ln_d2;
  end
  assign ln_out_data3 = ln_d3;

  ln_share_arb #(.DATAWIDTH(16), .NUM_REQ(4), .TAGW(2), .LN_LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .enable(enable0), .flush(flush0),
    .req_valid(req_valid0), .req_data(req_data0), .req_ready(req_ready0),
    .ln_in_data(ln_in_data0), .ln_in_valid(ln_in_valid0), .ln_out_data(ln_out_data0),
    .resp_valid(resp_valid0), .resp_data(resp_data0), .resp_tag(resp_tag0),
    .busy(busy0), .flush_done(flush_done0)
`ifdef LN_ARB_DOMAIN_CHK_EN
    , .dom_err(dom_err0), .dom_err_tag(dom_err_tag0)
`endif
  );

  ln_share_arb #(.DATAWIDTH(16), .NUM_REQ(4), .TAGW(2), .LN_LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .enable(enable3), .flush(flush3),
    .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
    .ln_in_data(ln_in_data3), .ln_in_valid(ln_in_valid3), .ln_out_data(ln_out_data3),
    .resp_valid(resp_valid3), .resp_data(resp_data3), .resp_tag(resp_tag3),
    .busy(busy3), .flush_done(flush_done3)
`ifdef LN_ARB_DOMAIN_CHK_EN
    , .dom_err(dom_err3), .dom_err_tag(dom_err_tag3)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic checkResp0();
    exp_t e;
    if (q0.size() > 0 && q0[0].due < cyc) begin
      checkOutput("dut0_resp_late", cyc, q0[0].due);
      void'(q0.pop_front());
    end
    if (resp_valid0 != 4'b0) begin
      if (q0.size() == 0) begin
        checkOutput("dut0_resp_unexpected", resp_valid0, 0);
      end else begin
        e = q0.pop_front();
        checkOutput("dut0_resp_cycle", cyc, e.due);
        checkOutput("dut0_resp_valid", resp_valid0, 4'b0001 << e.tag);
        checkOutput("dut0_resp_tag", resp_tag0, e.tag);
        checkOutput("dut0_resp_data", resp_data0, e.data);
      end
    end
  endtask

  task automatic checkResp3();
    exp_t e;
    if (q3.size() > 0 && q3[0].due < cyc) begin
      checkOutput("dut3_resp_late", cyc, q3[0].due);
      void'(q3.pop_front());
    end
    if (resp_valid3 != 4'b0) begin
      if (q3.size() == 0) begin
        checkOutput("dut3_resp_unexpected", resp_valid3, 0);
      end else begin
        e = q3.pop_front();
        checkOutput("dut3_resp_cycle", cyc, e.due);
        checkOutput("dut3_resp_valid", resp_valid3, 4'b0001 << e.tag);
        checkOutput("dut3_resp_tag", resp_tag3, e.tag);
        checkOutput("dut3_resp_data", resp_data3, e.data);
      end
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkResp0();
    checkResp3();
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d);
    req_valid0 = v;
    req_data0  = d;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    enable0 = 1'b0; flush0 = 1'b0; req_valid0 = '0; req_data0 = '0;
    enable3 = 1'b0; flush3 = 1'b0; req_valid3 = '0; req_data3 = '0;
    repeat (2) stepClock();

    // Reset state
    checkOutput("rst_req_ready", req_ready0, 0);
    checkOutput("rst_ln_in_valid", ln_in_valid0, 0);
    checkOutput("rst_ln_in_data", ln_in_data0, 0);
    checkOutput("rst_resp_valid", resp_valid0, 0);
    checkOutput("rst_resp_data", resp_data0, 0);
    checkOutput("rst_resp_tag", resp_tag0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_flush_done", flush_done0, 0);
    checkOutput("rst_busy3", busy3, 0);
`ifdef LN_ARB_DOMAIN_CHK_EN
    checkOutput("rst_dom_err", dom_err0, 0);
    checkOutput("rst_dom_err3", dom_err3, 0);
    checkOutput("rst_dom_err_tag3", dom_err_tag3, 0);
`endif

    resetn = 1'b1; enable0 = 1'b1; enable3 = 1'b1;
    stepClock();
    checkOutput("active_busy", busy0, 1);

    // Single request from lane 2
    applyStimulus(4'b0100, {16'h0, 16'h3C00, 16'h0, 16'h0});
    checkOutput("single_ready", req_ready0, 4'b0100);
    q0.push_back('{tag: 2'd2, data: ln_model(16'h3C00), due: cyc + 2});
    stepClock();
    applyStimulus(4'b0000, {16'h0, 16'h3C00, 16'h0, 16'h0});
    checkOutput("single_ln_in_valid", ln_in_valid0, 1);
    checkOutput("single_ln_in_data", ln_in_data0, 16'h3C00);
    stepClock();
    checkOutput("single_resp_valid", resp_valid0, 4'b0100);
    checkOutput("single_resp_tag", resp_tag0, 2);
    checkOutput("idle_ln_in_valid", ln_in_valid0, 0);
    checkOutput("idle_ln_in_hold", ln_in_data0, 16'h3C00);
    stepClock();
    checkOutput("resp_pulse_end", resp_valid0, 0);
    checkOutput("resp_tag_hold", resp_tag0, 2);

    // Latency-3 instance: lanes 1 and 3 back to back
    req_data3  = {16'h4400, 16'h0, 16'h4000, 16'h0};
    req_valid3 = 4'b0010; #1;
    checkOutput("lat_ready_lane1", req_ready3, 4'b0010);
    q3.push_back('{tag: 2'd1, data: ln_model(16'h4000), due: cyc + 5});
    stepClock();
    req_valid3 = 4'b1000; #1;
    checkOutput("lat_ready_lane3", req_ready3, 4'b1000);
    q3.push_back('{tag: 2'd3, data: ln_model(16'h4400), due: cyc + 5});
    stepClock();
    req_valid3 = 4'b0000;
    repeat (7) stepClock();
    checkOutput("lat_drained", q3.size(), 0);

    // Round-robin fairness from reset
    resetn = 1'b0; applyStimulus(4'b0000, '0);
    stepClock();
    resetn = 1'b1;
    stepClock();
    rrd = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, rrd);
      checkOutput($sformatf("rr_grant%0d", i), req_ready0, 4'b0001 << (i % 4));
      q0.push_back('{tag: 2'(i % 4), data: ln_model(rrd[(i % 4)*16 +: 16]), due: cyc + 2});
      stepClock();
    end
    applyStimulus(4'b0000, rrd);
    repeat (3) stepClock();
    checkOutput("rr_drained", q0.size(), 0);

    // Flush with three requests in flight
    for (int j = 1; j < 4; j++) begin
      applyStimulus(4'b0001 << j, rrd);
      checkOutput($sformatf("flush_pre_grant%0d", j), req_ready0, 4'b0001 << j);
      q0.push_back('{tag: 2'(j), data: ln_model(rrd[j*16 +: 16]), due: cyc + 2});
      last_due = cyc + 2;
      stepClock();
    end
    flush0 = 1'b1;
    applyStimulus(4'b0001, rrd);
    checkOutput("flush_ready_blocked", req_ready0, 0);
    checkOutput("flush_busy", busy0, 1);
    fd_count = 0;
    fd_cyc   = -1;
    for (int n = 0; n < 8; n++) begin
      stepClock();
      checkOutput("flush_ready_held", req_ready0, 0);
      if (flush_done0) begin
        fd_count++;
        fd_cyc = cyc;
      end
    end
    checkOutput("flush_done_count", fd_count, 1);
    checkOutput("flush_done_cycle", fd_cyc, last_due + 1);
    checkOutput("flush_busy_after", busy0, 0);
    checkOutput("flush_all_resp", q0.size(), 0);
    flush0 = 1'b0;
    applyStimulus(4'b0000, rrd);

`ifdef LN_ARB_DOMAIN_CHK_EN
    // Domain check: -1.0 from lane 1 then +0 from lane 2
    stepClock();
    checkOutput("dom_clean", dom_err0, 0);
    applyStimulus(4'b0010, {16'h0, 16'h0, 16'hBC00, 16'h0});
    checkOutput("dom_ready_lane1", req_ready0, 4'b0010);
    q0.push_back('{tag: 2'd1, data: ln_model(16'hBC00), due: cyc + 2});
    stepClock();
    applyStimulus(4'b0100, {16'h0, 16'h0000, 16'h0, 16'h0});
    checkOutput("dom_ready_lane2", req_ready0, 4'b0100);
    q0.push_back('{tag: 2'd2, data: ln_model(16'h0000), due: cyc + 2});
    stepClock();
    applyStimulus(4'b0000, '0);
    stepClock();
    checkOutput("dom_err_set", dom_err0, 1);
    checkOutput("dom_err_tag", dom_err_tag0, 1);
    flush0 = 1'b1;
    fd_count = 0;
    for (int n = 0; n < 8; n++) begin
      stepClock();
      if (flush_done0) begin
        fd_count = 1;
        break;
      end
    end
    checkOutput("dom_flush_done_seen", fd_count, 1);
    stepClock();
    checkOutput("dom_err_cleared", dom_err0, 0);
    flush0 = 1'b0;
`endif

    // Asynchronous reset with results in flight
    stepClock();
    req_data3  = {16'h4400, 16'h4200, 16'h4000, 16'h0};
    req_valid3 = 4'b0010;
    stepClock();
    req_valid3 = 4'b0100;
    applyStimulus(4'b0100, {16'h0, 16'h4200, 16'h0, 16'h0});
    checkOutput("arst_pre_ready", req_ready0, 4'b0100);
    stepClock();
    req_valid3 = 4'b0000;
    applyStimulus(4'b0000, '0);
    checkOutput("arst_pending0", ln_in_valid0, 1);
    checkOutput("arst_pending3", busy3, 1);
    resetn = 1'b0; #1;
    checkOutput("arst_ln_in_valid", ln_in_valid0, 0);
    checkOutput("arst_ln_in_data", ln_in_data0, 0);
    checkOutput("arst_busy", busy0, 0);
    checkOutput("arst_resp_valid", resp_valid0, 0);
    checkOutput("arst_busy3", busy3, 0);
    checkOutput("arst_ln_in_valid3", ln_in_valid3, 0);
    checkOutput("arst_ln_in_data3", ln_in_data3, 0);
    stepClock();
    resetn = 1'b1;
    stepClock();
    applyStimulus(4'b1001, {16'h4400, 16'h0, 16'h0, 16'h3C00});
    req_valid3 = 4'b1100; #1;
    checkOutput("arst_first_grant", req_ready0, 4'b0001);
    checkOutput("arst_first_grant3", req_ready3, 4'b0100);
    q0.push_back('{tag: 2'd0, data: ln_model(16'h3C00), due: cyc + 2});
    q3.push_back('{tag: 2'd2, data: ln_model(16'h4200), due: cyc + 5});
    stepClock();
    applyStimulus(4'b0000, '0);
    req_valid3 = 4'b0000;
    repeat (8) stepClock();
    checkOutput("end_q0_empty", q0.size(), 0);
    checkOutput("end_q3_empty", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
